// File: rtl/pmem_pkg.sv
// Shared types and helpers for the pmem_fetch program memory.
// Shared by every build; the optional parity feature is PMEM_PARITY_EN.
package pmem_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pmem_state_e;

    localparam logic [31:0] ILLEGAL_INSTR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic misaligned;
        logic out_of_range;
    } pc_flags_t;

    // Flags a PC whose byte-offset bits are non-zero, or whose bits above the word index are set.
    function automatic pc_flags_t pc_decode(input logic [63:0] pc, input int pc_w,
                                            input int off_w, input int idx_w);
        pc_flags_t f;
        f = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < off_w && pc[i]) f.misaligned = 1'b1;
            if (i >= off_w + idx_w && i < pc_w && pc[i]) f.out_of_range = 1'b1;
        end
        return f;
    endfunction

endpackage

// File: rtl/pmem_array.sv
// Word store with a synchronous write port and a registered read port.
// Contents are never reset; rdata only changes when re is asserted.
module pmem_array #(
    parameter int DEPTH = 32768,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/pmem_fetch.sv
// Program memory with a LOAD/RUN/DRAIN mode FSM, a load port and a 1-cycle fetch port.
// Optional macro PMEM_PARITY_EN adds a per-word even-parity bit and a sticky par_err output.
module pmem_fetch
    import pmem_pkg::*;
#(
    parameter int PC_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH = 32768,
    parameter logic [DATA_W-1:0] ILLEGAL_INSTR = DATA_W'(ILLEGAL_INSTR_DEFAULT),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_c0,
    output logic              req_ready_c0,
    input  logic [PC_W-1:0]   pc_c0,
    output logic              rsp_valid_c1,
    input  logic              rsp_ready_c1,
    output logic [DATA_W-1:0] instr_c1,
    output logic              err_c1,
    input  logic              ld_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [IDX_W-1:0]  ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              run
`ifdef PMEM_PARITY_EN
    ,
    output logic              par_err
`endif
);

    localparam int OFF_W = $clog2(DATA_W / 8);
`ifdef PMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    // Handshake rule for both ports: a transfer happens on a cycle where valid & ready are both high.
    pmem_state_e state, state_d;
    pc_flags_t   flags;
    logic        accept, wr_en, addr_err_q, rd_live_q, par_bad;
    logic [MEM_W-1:0] wdata, rdata;

    assign flags        = pc_decode(64'(pc_c0), PC_W, OFF_W, IDX_W);
    assign run          = (state == RUN);
    assign ld_ready     = (state == LOAD);
    assign req_ready_c0 = run && (!rsp_valid_c1 || rsp_ready_c1);
    assign accept       = req_valid_c0 && req_ready_c0;
    assign wr_en        = ld_valid && ld_ready;

`ifdef PMEM_PARITY_EN
    assign wdata   = {^ld_data, ld_data};
    assign par_bad = ^rdata;
`else
    assign wdata   = ld_data;
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_d = state;
        case (state)
            LOAD:    if (ld_valid && ld_last) state_d = RUN;
            RUN:     if (ld_start) state_d = DRAIN;
            DRAIN:   if (!rsp_valid_c1 || rsp_ready_c1) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LOAD;
            rsp_valid_c1 <= 1'b0;
            addr_err_q   <= 1'b0;
            rd_live_q    <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                rsp_valid_c1 <= 1'b1;
                addr_err_q   <= flags.misaligned || flags.out_of_range;
                rd_live_q    <= 1'b1;
            end else if (rsp_ready_c1) begin
                rsp_valid_c1 <= 1'b0;
            end
        end
    end

    // rd_live_q masks stale array output until the first fetch after reset.
    assign err_c1   = rd_live_q && (addr_err_q || par_bad);
    assign instr_c1 = (!rd_live_q || err_c1) ? ILLEGAL_INSTR : rdata[DATA_W-1:0];

`ifdef PMEM_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) par_err <= 1'b0;
        else if (rsp_valid_c1 && rd_live_q && par_bad) par_err <= 1'b1;
    end
`endif

    pmem_array #(.DEPTH(DEPTH), .WIDTH(MEM_W)) u_array (
        .clk   (clk),
        .we    (wr_en),
        .waddr (ld_addr),
        .wdata (wdata),
        .re    (accept),
        .raddr (pc_c0[OFF_W +: IDX_W]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_pmem_fetch.sv
// Directed self-checking bench for pmem_fetch (default parameters).
// Parity scenario is compiled in when PMEM_PARITY_EN is defined.
module tb_pmem_fetch;

    logic        clk, rst;
    logic        req_valid_c0, req_ready_c0;
    logic [31:0] pc_c0;
    logic        rsp_valid_c1, rsp_ready_c1;
    logic [31:0] instr_c1;
    logic        err_c1;
    logic        ld_start, ld_valid, ld_ready, ld_last, run;
    logic [14:0] ld_addr;
    logic [31:0] ld_data;
`ifdef PMEM_PARITY_EN
    logic        par_err;
`endif

    int n_checks = 0;
    int n_fail = 0;

    pmem_fetch dut (
        .clk(clk), .rst(rst),
        .req_valid_c0(req_valid_c0), .req_ready_c0(req_ready_c0), .pc_c0(pc_c0),
        .rsp_valid_c1(rsp_valid_c1), .rsp_ready_c1(rsp_ready_c1),
        .instr_c1(instr_c1), .err_c1(err_c1),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .run(run)
`ifdef PMEM_PARITY_EN
        , .par_err(par_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid_c0 = 0; pc_c0 = 0; rsp_ready_c1 = 0;
        ld_start = 0; ld_valid = 0; ld_addr = 0; ld_data = 0; ld_last = 0;
        tick(); tick();
        rst = 1'b0; #1;
        n_checks++; if (run !== 1'b0) begin n_fail++; $display("FAIL reset_run got %0b want 0", run); end
        n_checks++; if (rsp_valid_c1 !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid_c1); end
        n_checks++; if (instr_c1 !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 00000000", instr_c1); end
        n_checks++; if (err_c1 !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b want 0", err_c1); end
        n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready got %0b want 1", ld_ready); end
        n_checks++; if (req_ready_c0 !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got %0b want 0", req_ready_c0); end
    endtask

    task automatic test_load();
        logic [31:0] words [4];
        words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        ld_start = 1'b1;  // ignored while loading
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1; ld_addr = 15'(i); ld_data = words[i]; ld_last = (i == 3);
            tick();
            if (i < 3) begin
                n_checks++; if (run !== 1'b0) begin n_fail++; $display("FAIL load_run_early word %0d got %0b want 0", i, run); end
            end
        end
        ld_valid = 0; ld_last = 0; ld_start = 0;
        n_checks++; if (run !== 1'b1) begin n_fail++; $display("FAIL load_run got %0b want 1", run); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [3];
        logic [31:0] exp [3];
        pcs = '{32'h0, 32'h4, 32'hC};
        exp = '{32'h11111111, 32'h22222222, 32'h44444444};
        rsp_ready_c1 = 1;
        for (int i = 0; i < 3; i++) begin
            req_valid_c0 = 1; pc_c0 = pcs[i]; #1;
            n_checks++; if (req_ready_c0 !== 1'b1) begin n_fail++; $display("FAIL b2b_req_ready %0d got %0b want 1", i, req_ready_c0); end
            tick();
            n_checks++; if (rsp_valid_c1 !== 1'b1) begin n_fail++; $display("FAIL b2b_valid %0d got %0b want 1", i, rsp_valid_c1); end
            n_checks++; if (instr_c1 !== exp[i]) begin n_fail++; $display("FAIL b2b_instr %0d got %h want %h", i, instr_c1, exp[i]); end
            n_checks++; if (err_c1 !== 1'b0) begin n_fail++; $display("FAIL b2b_err %0d got %0b want 0", i, err_c1); end
        end
        req_valid_c0 = 0;
        tick();
        n_checks++; if (rsp_valid_c1 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_valid got %0b want 0", rsp_valid_c1); end
        n_checks++; if (instr_c1 !== 32'h44444444) begin n_fail++; $display("FAIL b2b_idle_instr got %h want 44444444", instr_c1); end
    endtask

    task automatic test_backpressure();
        rsp_ready_c1 = 0; req_valid_c0 = 1; pc_c0 = 32'h8;
        tick();
        pc_c0 = 32'h0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (instr_c1 !== 32'h33333333) begin n_fail++; $display("FAIL bp_hold_instr %0d got %h want 33333333", i, instr_c1); end
            n_checks++; if (rsp_valid_c1 !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid %0d got %0b want 1", i, rsp_valid_c1); end
            n_checks++; if (req_ready_c0 !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready %0d got %0b want 0", i, req_ready_c0); end
            tick();
        end
        rsp_ready_c1 = 1; #1;
        n_checks++; if (req_ready_c0 !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %0b want 1", req_ready_c0); end
        tick();
        n_checks++; if (instr_c1 !== 32'h11111111) begin n_fail++; $display("FAIL bp_next_instr got %h want 11111111", instr_c1); end
        req_valid_c0 = 0;
        tick();
    endtask

    task automatic test_errors();
        rsp_ready_c1 = 1; req_valid_c0 = 1; pc_c0 = 32'h6;
        tick();
        n_checks++; if (err_c1 !== 1'b1) begin n_fail++; $display("FAIL misalign_err got %0b want 1", err_c1); end
        n_checks++; if (instr_c1 !== 32'h0) begin n_fail++; $display("FAIL misalign_instr got %h want 00000000", instr_c1); end
        pc_c0 = 32'h0002_0000;
        tick();
        n_checks++; if (err_c1 !== 1'b1) begin n_fail++; $display("FAIL range_err got %0b want 1", err_c1); end
        n_checks++; if (instr_c1 !== 32'h0) begin n_fail++; $display("FAIL range_instr got %h want 00000000", instr_c1); end
        pc_c0 = 32'h4;
        tick();
        n_checks++; if (err_c1 !== 1'b0) begin n_fail++; $display("FAIL recover_err got %0b want 0", err_c1); end
        n_checks++; if (instr_c1 !== 32'h22222222) begin n_fail++; $display("FAIL recover_instr got %h want 22222222", instr_c1); end
        req_valid_c0 = 0;
        tick();
    endtask

    task automatic test_drain_reload();
        rsp_ready_c1 = 0; req_valid_c0 = 1; pc_c0 = 32'h0;
        tick();
        req_valid_c0 = 0; ld_start = 1;
        tick();
        ld_start = 0;
        // A load attempt during DRAIN must not land in memory.
        ld_valid = 1; ld_addr = 15'd2; ld_data = 32'hBAD0BAD0; ld_last = 1;
        n_checks++; if (run !== 1'b0) begin n_fail++; $display("FAIL drain_run got %0b want 0", run); end
        n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ld_ready got %0b want 0", ld_ready); end
        tick();
        n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL drain_hold_ld_ready got %0b want 0", ld_ready); end
        n_checks++; if (rsp_valid_c1 !== 1'b1) begin n_fail++; $display("FAIL drain_hold_valid got %0b want 1", rsp_valid_c1); end
        ld_valid = 0; ld_last = 0;
        rsp_ready_c1 = 1;
        tick();
        n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL drain_exit_ld_ready got %0b want 1", ld_ready); end
        n_checks++; if (rsp_valid_c1 !== 1'b0) begin n_fail++; $display("FAIL drain_exit_valid got %0b want 0", rsp_valid_c1); end
        ld_valid = 1; ld_addr = 15'd1; ld_data = 32'hDEADBEEF; ld_last = 1;
        tick();
        ld_valid = 0; ld_last = 0;
        n_checks++; if (run !== 1'b1) begin n_fail++; $display("FAIL reload_run got %0b want 1", run); end
        req_valid_c0 = 1; pc_c0 = 32'h4;
        tick();
        n_checks++; if (instr_c1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL reload_instr got %h want deadbeef", instr_c1); end
        pc_c0 = 32'h8;
        tick();
        n_checks++; if (instr_c1 !== 32'h33333333) begin n_fail++; $display("FAIL drain_nowrite got %h want 33333333", instr_c1); end
        req_valid_c0 = 0;
        tick();
    endtask

    task automatic test_reset_midway();
        rsp_ready_c1 = 0; req_valid_c0 = 1; pc_c0 = 32'h0;
        tick();
        req_valid_c0 = 0; rst = 1;
        tick();
        rst = 0;
        n_checks++; if (rsp_valid_c1 !== 1'b0) begin n_fail++; $display("FAIL rstfetch_valid got %0b want 0", rsp_valid_c1); end
        n_checks++; if (instr_c1 !== 32'h0) begin n_fail++; $display("FAIL rstfetch_instr got %h want 00000000", instr_c1); end
        n_checks++; if (run !== 1'b0) begin n_fail++; $display("FAIL rstfetch_run got %0b want 0", run); end
        ld_valid = 1; ld_addr = 15'd3; ld_data = 32'h55555555; ld_last = 0;
        tick();
        ld_valid = 0; rst = 1;
        tick();
        rst = 0;
        n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL rstload_ld_ready got %0b want 1", ld_ready); end
        ld_valid = 1; ld_addr = 15'd0; ld_data = 32'h11111111; ld_last = 1;
        tick();
        ld_valid = 0; ld_last = 0;
        n_checks++; if (run !== 1'b1) begin n_fail++; $display("FAIL rstload_run got %0b want 1", run); end
        rsp_ready_c1 = 1; req_valid_c0 = 1; pc_c0 = 32'h8;
        tick();
        n_checks++; if (instr_c1 !== 32'h33333333) begin n_fail++; $display("FAIL rstload_word2 got %h want 33333333", instr_c1); end
        pc_c0 = 32'hC;
        tick();
        n_checks++; if (instr_c1 !== 32'h55555555) begin n_fail++; $display("FAIL rstload_word3 got %h want 55555555", instr_c1); end
        req_valid_c0 = 0;
        tick();
    endtask

`ifdef PMEM_PARITY_EN
    task automatic test_parity();
        dut.u_array.mem[2] = dut.u_array.mem[2] ^ 33'h1;
        rsp_ready_c1 = 1; req_valid_c0 = 1; pc_c0 = 32'h8;
        tick();
        n_checks++; if (err_c1 !== 1'b1) begin n_fail++; $display("FAIL par_err_c1 got %0b want 1", err_c1); end
        n_checks++; if (instr_c1 !== 32'h0) begin n_fail++; $display("FAIL par_instr got %h want 00000000", instr_c1); end
        pc_c0 = 32'h0;
        tick();
        n_checks++; if (par_err !== 1'b1) begin n_fail++; $display("FAIL par_err_set got %0b want 1", par_err); end
        tick();
        n_checks++; if (err_c1 !== 1'b0) begin n_fail++; $display("FAIL par_clean_err got %0b want 0", err_c1); end
        n_checks++; if (par_err !== 1'b1) begin n_fail++; $display("FAIL par_err_sticky got %0b want 1", par_err); end
        req_valid_c0 = 0; rst = 1;
        tick();
        rst = 0;
        n_checks++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL par_err_clear got %0b want 0", par_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_drain_reload();
        test_reset_midway();
`ifdef PMEM_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
